// File: rtl/sha_pkg.sv
// Shared types and constants for the uart-sha output path: digest width, serializer
// state encoding and the ASCII line terminators used by the hex-text trailer.
package sha_pkg;

  localparam int DIGEST_W_DEF = 512;
  localparam int OUT_W_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    FIN  = 2'd2
  } ser_state_t;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  // Beats per digest: raw bytes, or two hex characters per byte plus CR/LF.
  function automatic int ser_beats(input int digest_w, input int out_w, input bit hex);
    return hex ? (2 * (digest_w / out_w) + 2) : (digest_w / out_w);
  endfunction

endpackage

// File: rtl/digest_serializer_if.sv
// Bus between the f_permutation digest producer, the serializer and the UART TX
// beat consumer. Also carries the serializer FSM state for observation.
interface digest_serializer_if
  import sha_pkg::*;
#(
  parameter int DIGEST_W = DIGEST_W_DEF,
  parameter int OUT_W    = OUT_W_DEF
);

  // Handshakes: the digest side is level/ack -- the producer holds digest_valid and
  // digest stable until it sees the one-cycle digest_ack pulse. The beat side is
  // strict valid/ready -- a beat moves on a clock edge where out_valid & out_ready,
  // and out_data/out_valid never change while out_valid=1 and out_ready=0.
  logic [DIGEST_W-1:0] digest;
  logic                digest_valid;
  logic                digest_ack;
  logic [OUT_W-1:0]    out_data;
  logic                out_valid;
  logic                out_ready;
  logic                busy;
  logic                done;
  ser_state_t          dbg_state;

  modport master (
    output digest, digest_valid, out_ready,
    input  digest_ack, out_data, out_valid, busy, done, dbg_state
  );

  modport slave (
    input  digest, digest_valid, out_ready,
    output digest_ack, out_data, out_valid, busy, done, dbg_state
  );

endinterface

// File: rtl/digest_serializer_hex_nibble_ascii.sv
// Converts one 4-bit value into its lowercase ASCII hex character.
module hex_nibble_ascii (
  input  logic [3:0] i_nibble,
  output logic [7:0] o_ascii
);

  // 'a' (0x61) minus 10 is 0x57, so letters share the same add-offset form as digits.
  always_comb begin
    if (i_nibble < 4'd10) begin
      o_ascii = 8'h30 + {4'd0, i_nibble};
    end else begin
      o_ascii = 8'h57 + {4'd0, i_nibble};
    end
  end

endmodule

// File: rtl/digest_serializer.sv
// Captures one DIGEST_W digest and streams it MSB first as OUT_W-bit beats to UART TX.
// Define DIGEST_SERIALIZER_HEX_ASCII_EN (OUT_W=8 only) to emit lowercase hex text + CR LF.
module digest_serializer
  import sha_pkg::*;
#(
  parameter int DIGEST_W = DIGEST_W_DEF,
  parameter int OUT_W    = OUT_W_DEF
) (
  input logic               clk,
  input logic               rst_n,
  digest_serializer_if.slave bus
);

  // DIGEST_W must be a multiple of OUT_W.
  localparam int NBEATS = DIGEST_W / OUT_W;
`ifdef DIGEST_SERIALIZER_HEX_ASCII_EN
  localparam int SHIFT     = 4;
  localparam int HEX_BEATS = 2 * NBEATS;
  localparam int TOTAL     = ser_beats(DIGEST_W, OUT_W, 1'b1);
`else
  localparam int SHIFT     = OUT_W;
  localparam int TOTAL     = ser_beats(DIGEST_W, OUT_W, 1'b0);
`endif
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(TOTAL - 1);

  ser_state_t          r_state;
  ser_state_t          w_state_nxt;
  logic [DIGEST_W-1:0] r_shreg;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ack;
  logic                w_capture;
  logic                w_xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_xfer      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.digest_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          w_xfer = 1'b1;
          if (r_cnt == LAST_BEAT) begin
            w_state_nxt = FIN;
          end
        end
      end
      FIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // The counter is cleared only on the way back to IDLE so a digest never wraps mid-stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= w_capture;
      if (w_capture) begin
        r_shreg <= bus.digest;
      end else if (w_xfer) begin
        r_shreg <= r_shreg << SHIFT;
      end
      if (r_state == FIN) begin
        r_cnt <= '0;
      end else if (w_xfer) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.digest_ack = r_ack;
  assign bus.out_valid  = (r_state == SEND);
  assign bus.busy       = (r_state != IDLE);
  assign bus.done       = (r_state == FIN);
  assign bus.dbg_state  = r_state;

`ifdef DIGEST_SERIALIZER_HEX_ASCII_EN
  logic [7:0]       w_ascii;
  logic [OUT_W-1:0] w_out_data;

  hex_nibble_ascii u_hex (
    .i_nibble (r_shreg[DIGEST_W-1 -: 4]),
    .o_ascii  (w_ascii)
  );

  // Gated to zero outside SEND so an idle shift register does not show as '0'.
  always_comb begin
    w_out_data = '0;
    if (r_state == SEND) begin
      if (r_cnt < CNT_W'(HEX_BEATS)) begin
        w_out_data = OUT_W'(w_ascii);
      end else if (r_cnt == CNT_W'(HEX_BEATS)) begin
        w_out_data = OUT_W'(CHAR_CR);
      end else begin
        w_out_data = OUT_W'(CHAR_LF);
      end
    end
  end

  assign bus.out_data = w_out_data;
`else
  assign bus.out_data = r_shreg[DIGEST_W-1 -: OUT_W];
`endif

endmodule

// File: tb/tb_digest_serializer.sv
// Directed bench for digest_serializer: binary/hex stream, backpressure, busy collision,
// asynchronous reset mid-stream; beats are checked against a model-filled queue.
module tb_digest_serializer;
  import sha_pkg::*;

  localparam int DW = 512;
  localparam int OW = 8;
`ifdef DIGEST_SERIALIZER_HEX_ASCII_EN
  localparam int NB = 2 * (DW / OW) + 2;
`else
  localparam int NB = DW / OW;
`endif

  logic clk;
  logic rst_n;

  digest_serializer_if #(.DIGEST_W(DW), .OUT_W(OW)) bus ();

  digest_serializer #(.DIGEST_W(DW), .OUT_W(OW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  logic [OW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int ack_cnt = 0;
  bit stall_prev = 1'b0;
  logic [OW-1:0] stall_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] c;
    case (n)
      4'h0: c = "0"; 4'h1: c = "1"; 4'h2: c = "2"; 4'h3: c = "3";
      4'h4: c = "4"; 4'h5: c = "5"; 4'h6: c = "6"; 4'h7: c = "7";
      4'h8: c = "8"; 4'h9: c = "9"; 4'ha: c = "a"; 4'hb: c = "b";
      4'hc: c = "c"; 4'hd: c = "d"; 4'he: c = "e"; default: c = "f";
    endcase
    return c;
  endfunction

  task automatic push_digest(input logic [DW-1:0] d);
`ifdef DIGEST_SERIALIZER_HEX_ASCII_EN
    for (int k = 0; k < 2 * (DW / OW); k++) exp_q.push_back(hex_char(d[DW-1-4*k -: 4]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`else
    for (int k = 0; k < DW / OW; k++) exp_q.push_back(d[DW-1-OW*k -: OW]);
`endif
  endtask

  // Monitor: samples on the falling edge, a beat counts when it will transfer at the next rise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) done_cnt++;
      if (bus.digest_ack) ack_cnt++;
      if (stall_prev) begin
        check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
        check("stall_data", {24'd0, bus.out_data}, {24'd0, stall_data});
      end
      if (bus.out_valid && bus.out_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) check("extra_beat", 32'd1, 32'd0);
        else check("beat", {24'd0, bus.out_data}, {24'd0, exp_q.pop_front()});
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_data = bus.out_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Driver tasks
  task automatic start_digest(input logic [DW-1:0] d);
    @(posedge clk); #1;
    bus.digest = d;
    bus.digest_valid = 1'b1;
    push_digest(d);
    @(posedge clk); #1;
    check("ack", {31'd0, bus.digest_ack}, 32'd1);
    check("valid_first", {31'd0, bus.out_valid}, 32'd1);
    bus.digest_valid = 1'b0;
  endtask

  task automatic wait_done(input bit bp, output int n, output bit busy_lost);
    bit [3:0] pat = 4'b1001;
    n = 0;
    busy_lost = 1'b0;
    while (n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (bp) bus.out_ready = pat[n % 4];
      if (bus.done) break;
      if (!bus.busy) busy_lost = 1'b1;
    end
    if (n >= 2000) check("done_timeout", 32'd0, 32'd1);
  endtask

  logic [DW-1:0] d_inc, d_ff, d_rnd;
  int n, m, base, acks_before, dones_before;
  bit busy_lost;

  initial begin
    for (int k = 0; k < DW / OW; k++) d_inc[DW-1-OW*k -: OW] = OW'(k + 1);
    d_ff = '1;
    for (int k = 0; k < DW / 32; k++) d_rnd[32*k +: 32] = $urandom;
    rst_n = 1'b0;
    bus.digest = '0;
    bus.digest_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_ack", {31'd0, bus.digest_ack}, 32'd0);
    check("rst_data", {24'd0, bus.out_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef DIGEST_SERIALIZER_HEX_ASCII_EN
    // Hex text: 0xA5 then zeros.
    bus.out_ready = 1'b1;
    start_digest({8'hA5, {(DW - 8){1'b0}}});
    check("hex_first", {24'd0, bus.out_data}, 32'h61);
    wait_done(1'b0, n, busy_lost);
    check("hex_len", n, NB);
    check("hex_q_empty", exp_q.size(), 0);
    check("hex_xfers", xfer_cnt, NB);
`endif

    // Basic stream, ready held high.
    bus.out_ready = 1'b1;
    base = xfer_cnt;
    start_digest(d_inc);
    wait_done(1'b0, n, busy_lost);
    check("basic_len", n, NB);
    check("basic_busy", {31'd0, busy_lost}, 32'd0);
    check("basic_xfers", xfer_cnt - base, NB);
    check("basic_q_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, bus.done}, 32'd0);
    check("idle_valid", {31'd0, bus.out_valid}, 32'd0);
    check("idle_busy", {31'd0, bus.busy}, 32'd0);

    // Backpressure with ready pattern 1,0,0,1.
    base = xfer_cnt;
    start_digest(d_inc);
    wait_done(1'b1, n, busy_lost);
    check("bp_xfers", xfer_cnt - base, NB);
    check("bp_q_empty", exp_q.size(), 0);
    check("bp_busy", {31'd0, busy_lost}, 32'd0);

    // Busy collision: second digest raised during beat 10 and held.
    bus.out_ready = 1'b1;
    base = xfer_cnt;
    start_digest(d_inc);
    for (int i = 0; i < 100 && xfer_cnt < base + 10; i++) begin
      @(posedge clk); #1;
    end
    check("coll_reach10", xfer_cnt - base, 10);
    acks_before = ack_cnt;
    bus.digest = d_ff;
    bus.digest_valid = 1'b1;
    push_digest(d_ff);
    wait_done(1'b0, n, busy_lost);
    check("coll_no_ack", ack_cnt - acks_before, 0);
    check("coll_first_len", xfer_cnt - base, NB);
    m = 0;
    while (m < 20) begin
      @(posedge clk); #1;
      m++;
      if (bus.digest_ack) break;
    end
    check("coll_ack_delay", m, 2);
    bus.digest_valid = 1'b0;
    wait_done(1'b0, n, busy_lost);
    check("coll_second_len", n, NB);
    check("coll_q_empty", exp_q.size(), 0);

    // Reset mid-stream, then a fresh digest.
    base = xfer_cnt;
    start_digest(d_rnd);
    for (int i = 0; i < 100 && xfer_cnt < base + 21; i++) begin
      @(posedge clk); #1;
    end
    dones_before = done_cnt;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_done", {31'd0, bus.done}, 32'd0);
    check("arst_data", {24'd0, bus.out_data}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("arst_no_done", done_cnt - dones_before, 0);
    base = xfer_cnt;
    start_digest(d_inc);
    wait_done(1'b0, n, busy_lost);
    check("post_rst_len", n, NB);
    check("post_rst_xfers", xfer_cnt - base, NB);
    check("post_rst_q_empty", exp_q.size(), 0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
